// File: rtl/rat_ckpt.sv
// Register alias table with a circular FIFO of checkpoints.
//
// Purpose: maps each architectural register to "pending in ROB" plus a ROB
// tag. Snapshots of the map are taken on branches and restored on
// mispredict. Completion broadcasts (CDB) clear matching pending bits in the
// live map and in every snapshot.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rs1, rs2            source lookup indices (combinational read + CDB bypass)
//   rs1/rs2_valid,_tag  1 = source still pending, with its ROB tag
//   rd, rat_we,
//   rob_tag_in          rename write
//   cdb_valid, cdb_tag  completion broadcast
//   ckpt_take           snapshot request
//   ckpt_id             slot the next take will use
//   ckpt_full           all slots live
//   ckpt_count          number of live checkpoints
//   restore_valid,
//   restore_id          rollback to a snapshot; that slot and younger are freed
//   release_valid       free the oldest checkpoint
//   flush               clear map and all checkpoints
module rat_ckpt #(
  parameter int NREG  = 32,
  parameter int TAG_W = 5,
  parameter int NCKPT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [$clog2(NREG)-1:0]    rs1,
  input  logic [$clog2(NREG)-1:0]    rs2,
  input  logic [$clog2(NREG)-1:0]    rd,
  input  logic                       rat_we,
  input  logic [TAG_W-1:0]           rob_tag_in,
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_tag,
  input  logic                       ckpt_take,
  output logic [$clog2(NCKPT)-1:0]   ckpt_id,
  output logic                       ckpt_full,
  output logic [$clog2(NCKPT):0]     ckpt_count,
  input  logic                       restore_valid,
  input  logic [$clog2(NCKPT)-1:0]   restore_id,
  input  logic                       release_valid,
  input  logic                       flush,
  output logic                       rs1_valid,
  output logic                       rs2_valid,
  output logic [TAG_W-1:0]           rs1_tag,
  output logic [TAG_W-1:0]           rs2_tag
);

  localparam int CW = $clog2(NCKPT);
  localparam logic [CW:0] PTR_ONE  = (CW+1)'(1);
  localparam logic [CW:0] PTR_FULL = (CW+1)'(NCKPT);

  // Live map
  logic [NREG-1:0]  pend_q, pend_d;
  logic [TAG_W-1:0] tag_q [NREG];
  logic [TAG_W-1:0] tag_d [NREG];

  // Snapshot storage
  logic [NREG-1:0]  ck_pend_q [NCKPT];
  logic [NREG-1:0]  ck_pend_d [NCKPT];
  logic [TAG_W-1:0] ck_tag_q  [NCKPT][NREG];
  logic [TAG_W-1:0] ck_tag_d  [NCKPT][NREG];

  // FIFO pointers carry one extra bit so full and empty are distinguishable
  logic [CW:0] head_q, head_d;
  logic [CW:0] tail_q, tail_d;

  logic [CW-1:0] rst_off;
  logic          take_ok;
  logic          rel_ok;

  assign ckpt_count = tail_q - head_q;
  assign ckpt_full  = (ckpt_count == PTR_FULL);
  assign ckpt_id    = tail_q[CW-1:0];

  // Source reads: a same-cycle CDB hit shows the operand as already ready
  assign rs1_tag   = tag_q[rs1];
  assign rs2_tag   = tag_q[rs2];
  assign rs1_valid = pend_q[rs1] && !(cdb_valid && (tag_q[rs1] == cdb_tag));
  assign rs2_valid = pend_q[rs2] && !(cdb_valid && (tag_q[rs2] == cdb_tag));

  // Distance of the restored slot from the head gives its pointer position,
  // which becomes the new tail.
  assign rst_off = restore_id - head_q[CW-1:0];
  assign take_ok = ckpt_take && !ckpt_full && !restore_valid && !flush;
  // Releasing the very slot being restored would free it twice; drop the release.
  assign rel_ok  = release_valid && (ckpt_count != '0) && !flush &&
                   !(restore_valid && (restore_id == head_q[CW-1:0]));

  // Map next state: source (live or snapshot), then CDB clear, then rename
  always_comb begin
    pend_d = pend_q;
    tag_d  = tag_q;
    if (restore_valid) begin
      pend_d = ck_pend_q[restore_id];
      tag_d  = ck_tag_q[restore_id];
    end
    if (cdb_valid) begin
      for (int i = 0; i < NREG; i++) begin
        if (pend_d[i] && (tag_d[i] == cdb_tag)) pend_d[i] = 1'b0;
      end
    end
    if (!restore_valid && rat_we && (rd != '0)) begin
      pend_d[rd] = 1'b1;
      tag_d[rd]  = rob_tag_in;
    end
    if (flush) begin
      pend_d = '0;
      for (int i = 0; i < NREG; i++) tag_d[i] = '0;
    end
    // x0 is hardwired ready
    pend_d[0] = 1'b0;
    tag_d[0]  = '0;
  end

  // Snapshot next state: CDB clear in every slot, then capture on take
  always_comb begin
    ck_pend_d = ck_pend_q;
    ck_tag_d  = ck_tag_q;
    if (cdb_valid) begin
      for (int k = 0; k < NCKPT; k++) begin
        for (int i = 0; i < NREG; i++) begin
          if (ck_pend_q[k][i] && (ck_tag_q[k][i] == cdb_tag)) ck_pend_d[k][i] = 1'b0;
        end
      end
    end
    if (take_ok) begin
      ck_pend_d[tail_q[CW-1:0]] = pend_d;
      ck_tag_d[tail_q[CW-1:0]]  = tag_d;
    end
  end

  // Pointer next state
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      if (rel_ok) head_d = head_q + PTR_ONE;
      if (restore_valid)  tail_d = head_q + {1'b0, rst_off};
      else if (take_ok)   tail_d = tail_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      for (int i = 0; i < NREG; i++) tag_q[i] <= '0;
      for (int k = 0; k < NCKPT; k++) begin
        ck_pend_q[k] <= '0;
        for (int i = 0; i < NREG; i++) ck_tag_q[k][i] <= '0;
      end
      head_q <= '0;
      tail_q <= '0;
    end else begin
      pend_q    <= pend_d;
      tag_q     <= tag_d;
      ck_pend_q <= ck_pend_d;
      ck_tag_q  <= ck_tag_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
    end
  end

endmodule

// File: tb/tb_rat_ckpt.sv
// Self-checking bench for rat_ckpt (NREG=32, TAG_W=5, NCKPT=4).
module tb_rat_ckpt;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1, rs2, rd;
  logic       rat_we;
  logic [4:0] rob_tag_in;
  logic       cdb_valid;
  logic [4:0] cdb_tag;
  logic       ckpt_take;
  logic [1:0] ckpt_id;
  logic       ckpt_full;
  logic [2:0] ckpt_count;
  logic       restore_valid;
  logic [1:0] restore_id;
  logic       release_valid;
  logic       flush;
  logic       rs1_valid, rs2_valid;
  logic [4:0] rs1_tag, rs2_tag;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_chk  = 0;
  int   n_fail = 0;

  rat_ckpt #(.NREG(32), .TAG_W(5), .NCKPT(4)) dut (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rd(rd), .rat_we(rat_we),
    .rob_tag_in(rob_tag_in), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .ckpt_take(ckpt_take), .ckpt_id(ckpt_id), .ckpt_full(ckpt_full),
    .ckpt_count(ckpt_count), .restore_valid(restore_valid),
    .restore_id(restore_id), .release_valid(release_valid), .flush(flush),
    .rs1_valid(rs1_valid), .rs2_valid(rs2_valid),
    .rs1_tag(rs1_tag), .rs2_tag(rs2_tag)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pack_rs(input logic v, input logic [4:0] t);
    return {26'd0, v, t};
  endfunction

  function automatic logic [31:0] pack_ck(input logic f, input logic [1:0] id, input logic [2:0] c);
    return {26'd0, f, id, c};
  endfunction

  function automatic logic [31:0] obs_rs1();
    return {26'd0, rs1_valid, rs1_tag};
  endfunction

  function automatic logic [31:0] obs_rs2();
    return {26'd0, rs2_valid, rs2_tag};
  endfunction

  function automatic logic [31:0] obs_ck();
    return {26'd0, ckpt_full, ckpt_id, ckpt_count};
  endfunction

  task automatic idle();
    rs1 = '0; rs2 = '0; rd = '0; rat_we = 1'b0; rob_tag_in = '0;
    cdb_valid = 1'b0; cdb_tag = '0; ckpt_take = 1'b0; restore_valid = 1'b0;
    restore_id = '0; release_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    step();
    rst = 1'b0;
  endtask

  task automatic rename(input logic [4:0] r, input logic [4:0] t);
    rat_we = 1'b1; rd = r; rob_tag_in = t;
  endtask

  task automatic test_reset();
    do_reset();
    rename(5'd5, 5'd3); ckpt_take = 1'b1;
    step();
    idle(); rst = 1'b1;
    step();
    rst = 1'b0; rs1 = 5'd5; rs2 = 5'd5;
    exp_q.push_back('{"reset_rs1", pack_rs(1'b0, 5'd0)});
    exp_q.push_back('{"reset_rs2", pack_rs(1'b0, 5'd0)});
    exp_q.push_back('{"reset_ckpt", pack_ck(1'b0, 2'd0, 3'd0)});
    #1;
    e = exp_q.pop_front(); n_chk++;
    if (obs_rs1() !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs_rs1(), e.val); end
    e = exp_q.pop_front(); n_chk++;
    if (obs_rs2() !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs_rs2(), e.val); end
    e = exp_q.pop_front(); n_chk++;
    if (obs_ck() !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs_ck(), e.val); end
  endtask

  task automatic test_rename_bypass();
    do_reset();
    rename(5'd5, 5'd7);
    exp_q.push_back('{"ren_pending", pack_rs(1'b1, 5'd7)});
    step();
    idle(); rs1 = 5'd5; #1;
    e = exp_q.pop_front(); n_chk++;
    if (obs_rs1() !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs_rs1(), e.val); end
    cdb_valid = 1'b1; cdb_tag = 5'd7;
    exp_q.push_back('{"ren_bypass", pack_rs(1'b0, 5'd7)});
    #1;
    e = exp_q.pop_front(); n_chk++;
    if (obs_rs1() !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs_rs1(), e.val); end
    exp_q.push_back('{"ren_cleared", pack_rs(1'b0, 5'd7)});
    step();
    idle(); rs1 = 5'd5; #1;
    e = exp_q.pop_front(); n_chk++;
    if (obs_rs1() !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs_rs1(), e.val); end
    // x0 ignores writes
    rename(5'd0, 5'd5);
    exp_q.push_back('{"ren_x0", pack_rs(1'b0, 5'd0)});
    step();
    idle(); rs1 = 5'd0; #1;
    e = exp_q.pop_front(); n_chk++;
    if (obs_rs1() !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs_rs1(), e.val); end
    // rename wins over same-cycle CDB clear of the same entry
    rename(5'd6, 5'd1);
    step();
    rename(5'd6, 5'd2); cdb_valid = 1'b1; cdb_tag = 5'd1;
    exp_q.push_back('{"ren_over_cdb", pack_rs(1'b1, 5'd2)});
    step();
    idle(); rs1 = 5'd6; #1;
    e = exp_q.pop_front(); n_chk++;
    if (obs_rs1() !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs_rs1(), e.val); end
  endtask

  task automatic test_ckpt_restore();
    do_reset();
    rename(5'd3, 5'd2);
    step();
    idle(); ckpt_take = 1'b1;
    exp_q.push_back('{"cr_take_id", pack_ck(1'b0, 2'd0, 3'd0)});
    #1;
    e = exp_q.pop_front(); n_chk++;
    if (obs_ck() !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs_ck(), e.val); end
    step();
    idle(); rename(5'd3, 5'd9);
    step();
    idle(); restore_valid = 1'b1; restore_id = 2'd0;
    exp_q.push_back('{"cr_pre_restore", pack_ck(1'b0, 2'd1, 3'd1)});
    #1;
    e = exp_q.pop_front(); n_chk++;
    if (obs_ck() !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs_ck(), e.val); end
    exp_q.push_back('{"cr_x3_restored", pack_rs(1'b1, 5'd2)});
    exp_q.push_back('{"cr_count", pack_ck(1'b0, 2'd0, 3'd0)});
    step();
    idle(); rs1 = 5'd3; #1;
    e = exp_q.pop_front(); n_chk++;
    if (obs_rs1() !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs_rs1(), e.val); end
    e = exp_q.pop_front(); n_chk++;
    if (obs_ck() !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs_ck(), e.val); end
  endtask

  task automatic test_stale_clear();
    do_reset();
    rename(5'd4, 5'd6);
    step();
    idle(); ckpt_take = 1'b1;
    step();
    idle(); cdb_valid = 1'b1; cdb_tag = 5'd6;
    step();
    idle(); restore_valid = 1'b1; restore_id = 2'd0;
    exp_q.push_back('{"stale_x4", pack_rs(1'b0, 5'd6)});
    step();
    idle(); rs1 = 5'd4; #1;
    e = exp_q.pop_front(); n_chk++;
    if (obs_rs1() !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs_rs1(), e.val); end
    // CDB in the same cycle as the take must land in the snapshot
    rename(5'd7, 5'd8);
    step();
    idle(); ckpt_take = 1'b1; cdb_valid = 1'b1; cdb_tag = 5'd8;
    step();
    idle(); rename(5'd7, 5'd9);
    step();
    idle(); restore_valid = 1'b1; restore_id = 2'd0;
    exp_q.push_back('{"stale_take_cdb", pack_rs(1'b0, 5'd8)});
    step();
    idle(); rs1 = 5'd7; #1;
    e = exp_q.pop_front(); n_chk++;
    if (obs_rs1() !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs_rs1(), e.val); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    release_valid = 1'b1;
    exp_q.push_back('{"fw_release_empty", pack_ck(1'b0, 2'd0, 3'd0)});
    step();
    idle(); #1;
    e = exp_q.pop_front(); n_chk++;
    if (obs_ck() !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs_ck(), e.val); end
    for (int k = 0; k < 4; k++) begin
      idle();
      exp_q.push_back('{$sformatf("fw_fill%0d", k), pack_ck(1'b0, 2'(k), 3'(k))});
      #1;
      e = exp_q.pop_front(); n_chk++;
      if (obs_ck() !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs_ck(), e.val); end
      ckpt_take = 1'b1; rename(5'd1, 5'(10 + k));
      step();
    end
    idle(); ckpt_take = 1'b1;
    exp_q.push_back('{"fw_full", pack_ck(1'b1, 2'd0, 3'd4)});
    #1;
    e = exp_q.pop_front(); n_chk++;
    if (obs_ck() !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs_ck(), e.val); end
    exp_q.push_back('{"fw_take_ignored", pack_ck(1'b1, 2'd0, 3'd4)});
    step();
    idle(); #1;
    e = exp_q.pop_front(); n_chk++;
    if (obs_ck() !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs_ck(), e.val); end
    release_valid = 1'b1;
    exp_q.push_back('{"fw_release", pack_ck(1'b0, 2'd0, 3'd3)});
    step();
    idle(); #1;
    e = exp_q.pop_front(); n_chk++;
    if (obs_ck() !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs_ck(), e.val); end
    ckpt_take = 1'b1; rename(5'd1, 5'd20);
    exp_q.push_back('{"fw_wrap_take", pack_ck(1'b1, 2'd1, 3'd4)});
    step();
    idle(); #1;
    e = exp_q.pop_front(); n_chk++;
    if (obs_ck() !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs_ck(), e.val); end
    // full: take dropped even with a coincident release
    ckpt_take = 1'b1; release_valid = 1'b1;
    exp_q.push_back('{"fw_full_take_rel", pack_ck(1'b0, 2'd1, 3'd3)});
    step();
    idle(); #1;
    e = exp_q.pop_front(); n_chk++;
    if (obs_ck() !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs_ck(), e.val); end
    // live slots 2,3,0; restore wrapped slot 0 with release of slot 2
    restore_valid = 1'b1; restore_id = 2'd0; release_valid = 1'b1;
    exp_q.push_back('{"fw_restore0_x1", pack_rs(1'b1, 5'd20)});
    exp_q.push_back('{"fw_restore0_ck", pack_ck(1'b0, 2'd0, 3'd1)});
    step();
    idle(); rs1 = 5'd1; #1;
    e = exp_q.pop_front(); n_chk++;
    if (obs_rs1() !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs_rs1(), e.val); end
    e = exp_q.pop_front(); n_chk++;
    if (obs_ck() !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs_ck(), e.val); end
    // restore of the head slot drops the coincident release
    restore_valid = 1'b1; restore_id = 2'd3; release_valid = 1'b1;
    exp_q.push_back('{"fw_restore_head_x1", pack_rs(1'b1, 5'd13)});
    exp_q.push_back('{"fw_restore_head_ck", pack_ck(1'b0, 2'd3, 3'd0)});
    step();
    idle(); rs1 = 5'd1; #1;
    e = exp_q.pop_front(); n_chk++;
    if (obs_rs1() !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs_rs1(), e.val); end
    e = exp_q.pop_front(); n_chk++;
    if (obs_ck() !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs_ck(), e.val); end
  endtask

  task automatic test_priority();
    do_reset();
    rename(5'd8, 5'd3);
    step();
    idle(); ckpt_take = 1'b1;
    step();
    idle(); restore_valid = 1'b1; restore_id = 2'd0; ckpt_take = 1'b1; rename(5'd8, 5'd30);
    exp_q.push_back('{"pri_restore_x8", pack_rs(1'b1, 5'd3)});
    exp_q.push_back('{"pri_restore_ck", pack_ck(1'b0, 2'd0, 3'd0)});
    step();
    idle(); rs1 = 5'd8; #1;
    e = exp_q.pop_front(); n_chk++;
    if (obs_rs1() !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs_rs1(), e.val); end
    e = exp_q.pop_front(); n_chk++;
    if (obs_ck() !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs_ck(), e.val); end
    ckpt_take = 1'b1;
    step();
    idle(); flush = 1'b1; ckpt_take = 1'b1; rename(5'd8, 5'd4);
    exp_q.push_back('{"pri_flush_x8", pack_rs(1'b0, 5'd0)});
    exp_q.push_back('{"pri_flush_ck", pack_ck(1'b0, 2'd0, 3'd0)});
    step();
    idle(); rs1 = 5'd8; #1;
    e = exp_q.pop_front(); n_chk++;
    if (obs_rs1() !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs_rs1(), e.val); end
    e = exp_q.pop_front(); n_chk++;
    if (obs_ck() !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs_ck(), e.val); end
    rename(5'd9, 5'd5); ckpt_take = 1'b1;
    step();
    idle(); rst = 1'b1; flush = 1'b1; ckpt_take = 1'b1; release_valid = 1'b1; rename(5'd10, 5'd6);
    exp_q.push_back('{"pri_rst_x9", pack_rs(1'b0, 5'd0)});
    exp_q.push_back('{"pri_rst_x10", pack_rs(1'b0, 5'd0)});
    exp_q.push_back('{"pri_rst_ck", pack_ck(1'b0, 2'd0, 3'd0)});
    step();
    rst = 1'b0; idle(); rs1 = 5'd9; rs2 = 5'd10; #1;
    e = exp_q.pop_front(); n_chk++;
    if (obs_rs1() !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs_rs1(), e.val); end
    e = exp_q.pop_front(); n_chk++;
    if (obs_rs2() !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs_rs2(), e.val); end
    e = exp_q.pop_front(); n_chk++;
    if (obs_ck() !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs_ck(), e.val); end
  endtask

  task automatic test_back_to_back();
    logic       mp [32];
    logic [4:0] mt [32];
    do_reset();
    for (int i = 0; i < 32; i++) begin mp[i] = 1'b0; mt[i] = '0; end
    for (int c = 0; c < 200; c++) begin
      idle();
      rat_we     = 1'($urandom_range(0, 1));
      rd         = 5'($urandom_range(0, 31));
      rob_tag_in = 5'($urandom_range(0, 7));
      cdb_valid  = 1'($urandom_range(0, 1));
      cdb_tag    = 5'($urandom_range(0, 7));
      rs1        = 5'($urandom_range(0, 31));
      rs2        = 5'($urandom_range(0, 31));
      exp_q.push_back('{"b2b_rs1", pack_rs(mp[rs1] && !(cdb_valid && mt[rs1] == cdb_tag), mt[rs1])});
      exp_q.push_back('{"b2b_rs2", pack_rs(mp[rs2] && !(cdb_valid && mt[rs2] == cdb_tag), mt[rs2])});
      #1;
      e = exp_q.pop_front(); n_chk++;
      if (obs_rs1() !== e.val) begin n_fail++; $display("FAIL %s cyc %0d: got %h expected %h", e.name, c, obs_rs1(), e.val); end
      e = exp_q.pop_front(); n_chk++;
      if (obs_rs2() !== e.val) begin n_fail++; $display("FAIL %s cyc %0d: got %h expected %h", e.name, c, obs_rs2(), e.val); end
      for (int i = 0; i < 32; i++) begin
        if (cdb_valid && mp[i] && mt[i] == cdb_tag) mp[i] = 1'b0;
      end
      if (rat_we && rd != 5'd0) begin mp[rd] = 1'b1; mt[rd] = rob_tag_in; end
      step();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_rename_bypass();
    test_ckpt_restore();
    test_stale_clear();
    test_full_wrap();
    test_priority();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
